or_gate_unit: RTL and testbench

Registered two-operand bitwise OR with a valid flag, a reduction-OR flag and a sticky OR accumulator. It is a leaf datapath primitive used wherever two flag or mask vectors are merged. Results are available one clock after the operands, or in the same cycle when built combinational. The accumulator gathers every bit that has been set across a run of operations until it is cleared.

---
 rtl/or_gate_pkg.sv | 24 ++
 rtl/or_gate_acc.sv | 38 +++
 rtl/or_gate_unit.sv | 61 ++++++
 tb/tb_or_gate_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/or_gate_pkg.sv
// Shared constants and accumulator action decode for the OR primitive.
package or_gate_pkg;

    localparam int unsigned OR_DEFAULT_WIDTH = 1;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_CLEAR,
        ACC_LOAD,
        ACC_MERGE
    } accOpE;

    // A clear that coincides with a qualifying operand reloads instead of zeroing.
    function automatic accOpE accSelect(input logic inValid, input logic accEn,
                                        input logic accClr);
        accOpE op;
        op = ACC_HOLD;
        if (accClr && inValid && accEn) op = ACC_LOAD;
        else if (accClr)                op = ACC_CLEAR;
        else if (inValid && accEn)      op = ACC_MERGE;
        return op;
    endfunction

endpackage

// File: rtl/or_gate_acc.sv
// Sticky OR accumulator with clear/load priority and reduction flag.
module or_gate_acc
    import or_gate_pkg::*;
#(
    parameter int unsigned WIDTH = OR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] orIn,
    output logic [WIDTH-1:0] acc,
    output logic             acc_any
);

    accOpE            accOp;
    logic [WIDTH-1:0] accNext;

    always_comb begin
        accOp   = accSelect(in_valid, acc_en, acc_clr);
        accNext = acc;
        unique case (accOp)
            ACC_CLEAR: accNext = '0;
            ACC_LOAD:  accNext = orIn;
            ACC_MERGE: accNext = acc | orIn;
            default:   accNext = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= accNext;
    end

    assign acc_any = |acc;

endmodule

// File: rtl/or_gate_unit.sv
// Two-operand bitwise OR with optional output register, valid flag and sticky accumulator.
module or_gate_unit
    import or_gate_pkg::*;
#(
    parameter int unsigned WIDTH        = OR_DEFAULT_WIDTH,
    parameter bit          REGISTER_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] Y,
    output logic             Y_any,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc,
    output logic             acc_any
);

    logic [WIDTH-1:0] orVal;

    assign orVal = A | B;

    generate
        if (REGISTER_OUT) begin : gReg
            // Y keeps its last result when no operand arrives; only the flag drops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    Y         <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) Y <= orVal;
                end
            end
        end else begin : gComb
            always_comb begin
                Y         = orVal;
                out_valid = in_valid;
            end
        end
    endgenerate

    assign Y_any = |Y;

    or_gate_acc #(
        .WIDTH (WIDTH)
    ) uAcc (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .acc_en   (acc_en),
        .acc_clr  (acc_clr),
        .orIn     (orVal),
        .acc      (acc),
        .acc_any  (acc_any)
    );

endmodule

// File: tb/tb_or_gate_unit.sv
// Scoreboard bench for or_gate_unit: registered 8-bit, registered 1-bit and combinational 8-bit builds.
module tb_or_gate_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // registered, WIDTH=8
    logic       iv8 = 1'b0, en8 = 1'b0, clr8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] y8, acc8;
    logic       yAny8, ov8, accAny8;

    // registered, WIDTH=1
    logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic [0:0] y1, acc1;
    logic       yAny1, ov1, accAny1;

    // combinational, WIDTH=8
    logic       ivC = 1'b0, enC = 1'b0;
    logic [7:0] aC = '0, bC = '0;
    logic [7:0] yC, accC;
    logic       yAnyC, ovC, accAnyC;

    or_gate_unit #(.WIDTH(8), .REGISTER_OUT(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8),
        .acc_en(en8), .acc_clr(clr8), .Y(y8), .Y_any(yAny8),
        .out_valid(ov8), .acc(acc8), .acc_any(accAny8)
    );

    or_gate_unit #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1),
        .acc_en(1'b0), .acc_clr(1'b0), .Y(y1), .Y_any(yAny1),
        .out_valid(ov1), .acc(acc1), .acc_any(accAny1)
    );

    or_gate_unit #(.WIDTH(8), .REGISTER_OUT(1'b0)) dutC (
        .clk(clk), .rst_n(rst_n), .in_valid(ivC), .A(aC), .B(bC),
        .acc_en(enC), .acc_clr(1'b0), .Y(yC), .Y_any(yAnyC),
        .out_valid(ovC), .acc(accC), .acc_any(accAnyC)
    );

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [7:0] sbQ[$];
    logic [7:0] mY = '0;
    logic [7:0] mAcc = '0;

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic runOp(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic en, input logic clr);
        iv8 = iv; a8 = a; b8 = b; en8 = en; clr8 = clr;
        @(posedge clk);
        #1;
        if (clr && iv && en) mAcc = a | b;
        else if (clr)        mAcc = '0;
        else if (iv && en)   mAcc = mAcc | a | b;
        if (iv) sbQ.push_back(a | b);
        chkVal("outValid", 32'(ov8), 32'(iv));
        if (ov8 && sbQ.size() > 0) mY = sbQ.pop_front();
        chkVal("y", 32'(y8), 32'(mY));
        chkVal("yAny", 32'(yAny8), 32'(|mY));
        chkVal("acc", 32'(acc8), 32'(mAcc));
        chkVal("accAny", 32'(accAny8), 32'(|mAcc));
    endtask

    initial begin
        #12;
        chkVal("rstY", 32'(y8), 32'h0);
        chkVal("rstYAny", 32'(yAny8), 32'h0);
        chkVal("rstOv", 32'(ov8), 32'h0);
        chkVal("rstAcc", 32'(acc8), 32'h0);
        chkVal("rstAccAny", 32'(accAny8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            iv1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            @(posedge clk);
            #1;
            chkVal("tt1Y", 32'(y1), 32'(ab[1] | ab[0]));
            chkVal("tt1Ov", 32'(ov1), 32'h1);
            chkVal("tt1YAny", 32'(yAny1), 32'(ab[1] | ab[0]));
        end
        iv1 = 1'b0;
        @(posedge clk);
        #1;
        chkVal("tt1Drop", 32'(ov1), 32'h0);
        chkVal("tt1Hold", 32'(y1), 32'h1);

        // WIDTH=8 patterns and hold
        runOp(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0);
        runOp(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        runOp(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) runOp(1'b0, 8'(($urandom)), 8'($urandom), 1'b0, 1'b0);

        // accumulator
        runOp(1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
        runOp(1'b1, 8'h00, 8'h10, 1'b1, 1'b0);
        runOp(1'b1, 8'h80, 8'h00, 1'b1, 1'b0);
        chkVal("acc91", 32'(acc8), 32'h91);
        runOp(1'b1, 8'h02, 8'h00, 1'b1, 1'b1);
        chkVal("accClrLoad", 32'(acc8), 32'h02);
        runOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chkVal("accClr", 32'(acc8), 32'h00);
        runOp(1'b1, 8'h44, 8'h00, 1'b1, 1'b0);
        runOp(1'b0, 8'h08, 8'h00, 1'b1, 1'b0);
        runOp(1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
        runOp(1'b1, 8'h20, 8'h01, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++)
            runOp(1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 4) == 0));

        // asynchronous reset mid-cycle
        runOp(1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chkVal("arY", 32'(y8), 32'h0);
        chkVal("arYAny", 32'(yAny8), 32'h0);
        chkVal("arOv", 32'(ov8), 32'h0);
        chkVal("arAcc", 32'(acc8), 32'h0);
        chkVal("arAccAny", 32'(accAny8), 32'h0);
        sbQ.delete();
        mY = '0;
        mAcc = '0;
        iv8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runOp(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        runOp(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        runOp(1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
        runOp(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chkVal("sbLeft", 32'(sbQ.size()), 32'h0);

        // combinational build, no clock edge between drive and check
        @(posedge clk);
        #1;
        aC = 8'h01; bC = 8'h00; ivC = 1'b1;
        #1;
        chkVal("combY", 32'(yC), 32'h01);
        chkVal("combOv", 32'(ovC), 32'h1);
        chkVal("combYAny", 32'(yAnyC), 32'h1);
        aC = 8'h80; bC = 8'h04; enC = 1'b1;
        #1;
        chkVal("combY2", 32'(yC), 32'h84);
        chkVal("combAccPre", 32'(accC), 32'h00);
        @(posedge clk);
        #1;
        chkVal("combAcc", 32'(accC), 32'h84);
        chkVal("combAccAny", 32'(accAnyC), 32'h1);
        ivC = 1'b0; aC = 8'h00; bC = 8'h00;
        #1;
        chkVal("combOvLow", 32'(ovC), 32'h0);
        chkVal("combYZero", 32'(yC), 32'h00);
        chkVal("combYAnyZero", 32'(yAnyC), 32'h0);
        @(posedge clk);
        #1;
        chkVal("combAccHold", 32'(accC), 32'h84);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
